// File: rtl/codificacao.sv
// RV32I instruction encoder and program-memory loader: packs decoded fields into a
// 32-bit word and writes it at an auto-incrementing address. Optional request
// validation is enabled with the CODIFICACAO_ERRO_EN macro.
//
// Handshake: a request transfers on a rising edge where valido & pronto are both 1;
// all fields are captured on that edge, and inputs are ignored while pronto is 0.
module codificacao #(
  parameter int                ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valido,
  output logic              pronto,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       immediate,
  input  logic [2:0]        tipo,
  input  logic              negativo,
  output logic              mem_escrita,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [31:0]       mem_dado,
  output logic [31:0]       instrucao,
  output logic              erro
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CODIFICA = 2'd1,
    ESCREVE  = 2'd2
  } estado_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;
    logic [2:0]  tipo;
    logic        neg;
  } campos_t;

  localparam logic [2:0] T_LOAD  = 3'b000;
  localparam logic [2:0] T_ARITH = 3'b001;
  localparam logic [2:0] T_S     = 3'b010;
  localparam logic [2:0] T_R     = 3'b011;
  localparam logic [2:0] T_SB    = 3'b110;

  estado_t           estado_q, estado_d;
  campos_t           campos_q, campos_d;
  logic [31:0]       instrucao_q, instrucao_d;
  logic              erro_q, erro_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [31:0] palavra;
  logic [11:0] imm_i;
  logic [11:0] imm_b;
  logic        tipo_ok;
  logic        rejeita;
  logic        sinaliza;

  // Word assembly from the captured fields; negative immediates arrive as magnitudes.
  always_comb begin
    imm_i   = campos_q.neg ? (~campos_q.imm) + 12'd1 : campos_q.imm;
    imm_b   = (~{1'b0, campos_q.imm[11:1]}) + 12'd1;
    palavra = '0;
    case (campos_q.tipo)
      T_LOAD:  palavra = {campos_q.imm, campos_q.rs1, campos_q.funct3,
                          campos_q.rd, campos_q.opcode};
      T_ARITH: palavra = {imm_i, campos_q.rs1, campos_q.funct3,
                          campos_q.rd, campos_q.opcode};
      T_S:     palavra = {campos_q.imm[11:5], campos_q.rs2, campos_q.rs1,
                          campos_q.funct3, campos_q.imm[4:0], campos_q.opcode};
      T_R:     palavra = {campos_q.funct7, campos_q.rs2, campos_q.rs1,
                          campos_q.funct3, campos_q.rd, campos_q.opcode};
      T_SB: begin
        if (campos_q.neg) begin
          palavra = {imm_b[11], imm_b[9:4], campos_q.rs2, campos_q.rs1,
                     campos_q.funct3, imm_b[3:0], imm_b[10], campos_q.opcode};
        end else begin
          palavra = {campos_q.imm[11:5], campos_q.rs2, campos_q.rs1,
                     campos_q.funct3, campos_q.imm[4:0], campos_q.opcode};
        end
      end
      default: palavra = '0;
    endcase
  end

  always_comb begin
    tipo_ok = (campos_q.tipo == T_LOAD) || (campos_q.tipo == T_ARITH) ||
              (campos_q.tipo == T_S)    || (campos_q.tipo == T_R)     ||
              (campos_q.tipo == T_SB);
`ifdef CODIFICACAO_ERRO_EN
    rejeita = !tipo_ok ||
              (campos_q.opcode[6:4] != campos_q.tipo) ||
              ((campos_q.tipo == T_ARITH) && !campos_q.neg && campos_q.imm[11]) ||
              ((campos_q.tipo == T_SB) && !campos_q.neg && campos_q.imm[11]) ||
              ((campos_q.tipo == T_SB) && campos_q.neg &&
               ((campos_q.imm == 12'd0) || campos_q.imm[0]));
    sinaliza = rejeita;
`else
    // Unlisted formats are dropped without raising erro.
    rejeita  = !tipo_ok;
    sinaliza = 1'b0;
`endif
  end

  always_comb begin
    estado_d    = estado_q;
    campos_d    = campos_q;
    instrucao_d = instrucao_q;
    erro_d      = erro_q;
    ptr_d       = ptr_q;
    case (estado_q)
      OCIOSO: begin
        if (valido) begin
          campos_d = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3,
                       funct7: funct7, imm: immediate, tipo: tipo, neg: negativo};
          erro_d   = 1'b0;
          estado_d = CODIFICA;
        end
      end
      CODIFICA: begin
        erro_d = sinaliza;
        if (rejeita) begin
          estado_d = OCIOSO;
        end else begin
          instrucao_d = palavra;
          estado_d    = ESCREVE;
        end
      end
      ESCREVE: begin
        ptr_d    = ptr_q + ADDR_W'(4);
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      campos_q    <= '0;
      instrucao_q <= '0;
      erro_q      <= 1'b0;
      ptr_q       <= BASE;
    end else begin
      estado_q    <= estado_d;
      campos_q    <= campos_d;
      instrucao_q <= instrucao_d;
      erro_q      <= erro_d;
      ptr_q       <= ptr_d;
    end
  end

  assign pronto       = (estado_q == OCIOSO);
  assign mem_escrita  = (estado_q == ESCREVE);
  assign mem_endereco = ptr_q;
  assign mem_dado     = instrucao_q;
  assign instrucao    = instrucao_q;
  assign erro         = erro_q;

endmodule

// File: tb/tb_codificacao.sv
// Directed bench for codificacao: scoreboard queues of expected words/addresses,
// checked with immediate assertions when the write pulse appears.
module tb_codificacao;

  logic        clk = 1'b0;
  logic        reset;
  logic        valido, valido4;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] immediate;
  logic [2:0]  tipo;
  logic        negativo;

  logic        pronto, mem_escrita, erro;
  logic [7:0]  mem_endereco;
  logic [31:0] mem_dado, instrucao;

  logic        pronto4, mem_escrita4, erro4;
  logic [3:0]  mem_endereco4;
  logic [31:0] mem_dado4, instrucao4;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [3:0]  exp_addr4_q[$];
  logic [7:0]  exp_ptr;

  always #5 clk = ~clk;

  codificacao #(.ADDR_W(8), .BASE(8'h00)) u_dut (
    .clk(clk), .reset(reset), .valido(valido), .pronto(pronto),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .immediate(immediate), .tipo(tipo), .negativo(negativo),
    .mem_escrita(mem_escrita), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .instrucao(instrucao), .erro(erro)
  );

  codificacao #(.ADDR_W(4), .BASE(4'h0)) u_dut4 (
    .clk(clk), .reset(reset), .valido(valido4), .pronto(pronto4),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .immediate(immediate), .tipo(tipo), .negativo(negativo),
    .mem_escrita(mem_escrita4), .mem_endereco(mem_endereco4), .mem_dado(mem_dado4),
    .instrucao(instrucao4), .erro(erro4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [11:0] imm, input logic [2:0] tp, input logic neg);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
    immediate = imm; tipo = tp; negativo = neg;
  endtask

  // Compare the current write pulse against the head of the scoreboard.
  task automatic pop_chk(input string tag);
    chk({tag, "_escrita"}, {31'd0, mem_escrita}, 32'd1);
    chk({tag, "_qvazia"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      chk({tag, "_dado"}, mem_dado, exp_q.pop_front());
      chk({tag, "_end"}, {24'd0, mem_endereco}, {24'd0, exp_addr_q.pop_front()});
    end
  endtask

  // One full request; the caller has set the fields. wr says whether a write is due.
  task automatic send(input string tag, input logic wr, input logic [31:0] w);
    logic found;
    for (int i = 0; i < 8 && !pronto; i++) tick();
    chk({tag, "_pronto_in"}, {31'd0, pronto}, 32'd1);
    valido = 1'b1;
    tick();
    valido = 1'b0;
    chk({tag, "_pronto_c1"}, {31'd0, pronto}, 32'd0);
    chk({tag, "_erro_clr"}, {31'd0, erro}, 32'd0);
    if (wr) begin
      exp_q.push_back(w);
      exp_addr_q.push_back(exp_ptr);
      exp_ptr = exp_ptr + 8'd4;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
        tick();
        if (mem_escrita) begin
          found = 1'b1;
          pop_chk(tag);
          chk({tag, "_instrucao"}, instrucao, w);
        end
      end
      chk({tag, "_found"}, {31'd0, found}, 32'd1);
      tick();
      chk({tag, "_pronto_out"}, {31'd0, pronto}, 32'd1);
      chk({tag, "_escrita_off"}, {31'd0, mem_escrita}, 32'd0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk({tag, "_sem_escrita"}, {31'd0, mem_escrita}, 32'd0);
      end
      chk({tag, "_pronto_out"}, {31'd0, pronto}, 32'd1);
    end
  endtask

  function automatic logic [31:0] modelo_r(input logic [6:0] f7, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [2:0] f3,
                                           input logic [4:0] d, input logic [6:0] op);
    return (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
           (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
  endfunction

  function automatic logic [31:0] modelo_s(input logic [11:0] imm, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [2:0] f3,
                                           input logic [6:0] op);
    return ((32'(imm) >> 5) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
           (32'(f3) << 12) | ((32'(imm) & 32'h1F) << 7) | 32'(op);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    logic [4:0]  r_d, r_s1, r_s2;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [11:0] r_imm;

    reset = 1'b1; valido = 1'b0; valido4 = 1'b0; exp_ptr = 8'h00;
    set_fields(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 3'd0, 1'b0);
    tick(); tick(); tick();
    chk("rst_pronto", {31'd0, pronto}, 32'd1);
    chk("rst_escrita", {31'd0, mem_escrita}, 32'd0);
    chk("rst_end", {24'd0, mem_endereco}, 32'd0);
    chk("rst_dado", mem_dado, 32'd0);
    chk("rst_instrucao", instrucao, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    reset = 1'b0;
    tick();

    // addi then add back-to-back with valido held high
    set_fields(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'd5, 3'b001, 1'b1);
    valido = 1'b1;
    exp_q.push_back(32'hFFB10093); exp_addr_q.push_back(8'h00);
    exp_q.push_back(32'h002081B3); exp_addr_q.push_back(8'h04);
    exp_ptr = 8'h08;
    tick();
    chk("b2b_pronto_a1", {31'd0, pronto}, 32'd0);
    set_fields(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 3'b011, 1'b0);
    tick();
    chk("b2b_pronto_a2", {31'd0, pronto}, 32'd0);
    chk("addi_instrucao", instrucao, 32'hFFB10093);
    pop_chk("addi");
    tick();
    chk("b2b_pronto_a3", {31'd0, pronto}, 32'd1);
    tick();
    chk("b2b_pronto_b1", {31'd0, pronto}, 32'd0);
    valido = 1'b0;
    tick();
    chk("b2b_pronto_b2", {31'd0, pronto}, 32'd0);
    pop_chk("add");
    tick();
    chk("b2b_pronto_b3", {31'd0, pronto}, 32'd1);
    chk("b2b_escrita_off", {31'd0, mem_escrita}, 32'd0);

    set_fields(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 12'd8, 3'b010, 1'b0);
    send("sw", 1'b1, 32'h00512423);
    set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'd8, 3'b110, 1'b1);
    send("beq", 1'b1, 32'hFE208CE3);

    for (int k = 0; k < 4; k++) begin
      r_d = 5'($urandom_range(0, 31)); r_s1 = 5'($urandom_range(0, 31));
      r_s2 = 5'($urandom_range(0, 31)); r_f3 = 3'($urandom_range(0, 7));
      r_f7 = 7'($urandom_range(0, 127)); r_imm = 12'($urandom_range(0, 4095));
      set_fields(7'h33, r_d, r_s1, r_s2, r_f3, r_f7, r_imm, 3'b011, 1'b0);
      send("rnd_r", 1'b1, modelo_r(r_f7, r_s2, r_s1, r_f3, r_d, 7'h33));
      set_fields(7'h23, r_d, r_s1, r_s2, r_f3, r_f7, r_imm, 3'b010, 1'($urandom_range(0, 1)));
      send("rnd_s", 1'b1, modelo_s(r_imm, r_s2, r_s1, r_f3, 7'h23));
    end

`ifdef CODIFICACAO_ERRO_EN
    set_fields(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'h800, 3'b001, 1'b0);
    send("rej_imm", 1'b0, 32'd0);
    chk("rej_imm_erro", {31'd0, erro}, 32'd1);
    set_fields(7'h33, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'd0, 3'b001, 1'b0);
    send("rej_op", 1'b0, 32'd0);
    chk("rej_op_erro", {31'd0, erro}, 32'd1);
    set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'd3, 3'b110, 1'b1);
    send("rej_b_impar", 1'b0, 32'd0);
    chk("rej_b_erro", {31'd0, erro}, 32'd1);
`else
    set_fields(7'h43, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0, 3'b100, 1'b0);
    send("drop_tipo", 1'b0, 32'd0);
    chk("drop_erro", {31'd0, erro}, 32'd0);
`endif
    set_fields(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'd5, 3'b001, 1'b1);
    send("pos_rej", 1'b1, 32'hFFB10093);
    chk("pos_rej_erro", {31'd0, erro}, 32'd0);

    // reset during CODIFICA aborts the request and rewinds the pointer
    set_fields(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 3'b011, 1'b0);
    valido = 1'b1;
    tick();
    valido = 1'b0;
    chk("mid_codifica", {31'd0, pronto}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ptr = 8'h00;
    chk("mid_pronto", {31'd0, pronto}, 32'd1);
    chk("mid_escrita", {31'd0, mem_escrita}, 32'd0);
    chk("mid_end", {24'd0, mem_endereco}, 32'd0);
    chk("mid_instrucao", instrucao, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_sem_escrita", {31'd0, mem_escrita}, 32'd0);
    end
    set_fields(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 12'd8, 3'b010, 1'b0);
    send("pos_reset", 1'b1, 32'h00512423);

    // 4-bit pointer wraps after four writes
    exp_addr4_q.push_back(4'h0); exp_addr4_q.push_back(4'h4);
    exp_addr4_q.push_back(4'h8); exp_addr4_q.push_back(4'hC);
    exp_addr4_q.push_back(4'h0);
    set_fields(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'd5, 3'b001, 1'b1);
    valido4 = 1'b1;
    nw = 0;
    for (int i = 0; i < 40 && nw < 5; i++) begin
      tick();
      if (mem_escrita4) begin
        chk("wrap_end", {28'd0, mem_endereco4}, {28'd0, exp_addr4_q.pop_front()});
        chk("wrap_dado", mem_dado4, 32'hFFB10093);
        nw++;
        if (nw == 5) valido4 = 1'b0;
      end
    end
    chk("wrap_count", nw, 32'd5);
    tick(); tick();
    chk("wrap_idle", {31'd0, pronto4}, 32'd1);
    chk("sb_vazio", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
